// File: rtl/c1355_test_pkg.sv
// Shared definitions for the c1355 aging-test blocks: core widths, default
// MISR polynomial/seed and the response-checker FSM state type.
package c1355_test_pkg;

    localparam int C1355_OUT_W = 32;
    localparam int C1355_IN_W  = 41;

    localparam logic [C1355_OUT_W-1:0] DEF_POLY = 32'h04C1_1DB7;
    localparam logic [C1355_OUT_W-1:0] DEF_SEED = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/c1355_misr_checker_misr_core.sv
// Multiple-input signature register: shift left, fold the shifted-out MSB back
// through POLY, XOR in the parallel data word. Load has priority over enable.
module misr_core
    import c1355_test_pkg::*;
#(
    parameter int                DATA_W = C1355_OUT_W,
    parameter logic [DATA_W-1:0] POLY   = DEF_POLY
) (
    input  logic              clk,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] sig,
    output logic [DATA_W-1:0] sig_next
);

    logic [DATA_W-1:0] sig_q;
    logic [DATA_W-1:0] sig_d;
    logic [DATA_W-1:0] step;

    // One GF(2) MISR step and the load/enable/hold selection.
    always_comb begin
        step  = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? POLY : '0) ^ data_in;
        sig_d = sig_q;
        if (load) begin
            sig_d = load_val;
        end else if (en) begin
            sig_d = step;
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        sig_q <= sig_d;
    end

    assign sig      = sig_q;
    // Value the register would take if enabled this edge; the top compares it
    // against golden so pass lands on the same edge as the final capture.
    assign sig_next = step;

endmodule

// File: rtl/c1355_misr_checker.sv
// Response compactor for the c1355 core: folds VEC_LEN valid output words into
// a MISR and compares the final signature against golden.
// Handshake: a word is absorbed on every rising edge where resp_valid=1 while
// busy=1 (no ready; the checker never stalls). abort outranks resp_valid.
module c1355_misr_checker
    import c1355_test_pkg::*;
#(
    parameter int                DATA_W  = C1355_OUT_W,
    parameter int                VEC_LEN = 64,
    parameter logic [DATA_W-1:0] POLY    = DEF_POLY,
    parameter logic [DATA_W-1:0] SEED    = DEF_SEED,
    localparam int               CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp,
    input  logic [DATA_W-1:0] golden,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] signature,
    output logic [CNT_W-1:0]  vec_count,
    output logic [1:0]        state_dbg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic              misr_load;
    logic              misr_en;
    logic [DATA_W-1:0] sig_cur;
    logic [DATA_W-1:0] sig_next;

    // MISR control: seed on reset or on any accepted start, capture only in RUN.
    always_comb begin
        misr_load = 1'b0;
        misr_en   = 1'b0;
        if (!rst_n) begin
            misr_load = 1'b1;
        end else if (start && (state_q != RUN)) begin
            misr_load = 1'b1;
        end else if ((state_q == RUN) && !abort && resp_valid) begin
            misr_en = 1'b1;
        end
    end

    misr_core #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_misr (
        .clk      (clk),
        .load     (misr_load),
        .load_val (SEED),
        .en       (misr_en),
        .data_in  (resp),
        .sig      (sig_cur),
        .sig_next (sig_next)
    );

    // Run-control FSM with capture counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (resp_valid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if ((cnt_q + CNT_ONE) == LAST_CNT) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_next == golden);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_cur;
    assign vec_count = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: doc/c1355_misr_checker.md
# c1355_misr_checker

Response compactor that sits directly downstream of the c1355 combinational core in the aging test setup. It captures the 32-bit c1355 output word on every valid cycle and folds it into a multiple-input signature register (MISR). After a programmed number of vectors it compares the signature against a golden value and reports pass/fail. This lets long random-vector aging runs be checked on-chip or in HSPICE/RTL co-simulation without dumping every output word.

## Interface
- DATA_W, 32, response width; matches the c1355 outputs G1324..G1355, with G1324 as the MSB.
- VEC_LEN, 64, number of responses compacted per run; legal range 1..65535.
- POLY, 32'h04C1_1DB7, MISR feedback polynomial; bit i set means the shifted-out MSB is XORed into bit i.
- SEED, 32'h0000_0000, signature value loaded at start.
- CNT_W, $clog2(VEC_LEN+1), counter width; derived, not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run.
- abort  in  1  cancels a run in progress.
- resp_valid  in  1  resp holds a settled c1355 output word this cycle.
- resp  in  DATA_W  c1355 output word.
- golden  in  DATA_W  expected final signature; sampled at the final capture edge.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  compare result; meaningful only while done=1.
- signature  out  DATA_W  current MISR contents.
- vec_count  out  CNT_W  responses captured in the current run.

## Operation
The block is a three-state FSM: IDLE, RUN and DONE.
- Reset (rst_n=0 at an edge):
  - state goes to IDLE.
  - signature=SEED, vec_count=0.
  - busy=0, done=0, pass=0.
  - Reset takes priority over every other input, including mid-run.
- IDLE, start=1: go to RUN; signature←SEED, vec_count←0.
- RUN:
  - On each edge with resp_valid=1:
    - signature ← {signature[DATA_W-2:0],1'b0} ^ (signature[DATA_W-1] ? POLY : 0) ^ resp.
    - vec_count ← vec_count+1.
  - When the capture makes vec_count reach VEC_LEN:
    - go to DONE.
    - pass ← (next signature == golden), computed from the same-edge next value.
  - abort=1: go to IDLE; the capture is not performed; done and pass stay 0.
  - abort has priority over resp_valid in the same cycle.
  - start is ignored in RUN.
- DONE:
  - signature, vec_count and pass hold.
  - start=1: restart directly into RUN with signature←SEED, vec_count←0, pass←0.
  - abort=1: go to IDLE and clear pass.
- resp_valid is ignored in IDLE and DONE.
- resp is treated as data only; no X-checking.
- Arithmetic:
  - The MISR is GF(2) only; there are no carries.
  - The counter never wraps, because the run ends exactly at VEC_LEN.

## Timing
- start→busy latency: 1 cycle.
- Each valid response is absorbed in one cycle, with no stalls; resp_valid may be high on every cycle.
- done and pass assert on the same edge that captures the VEC_LEN-th response, so they are visible in the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- golden must be stable on the final capture edge.

## Structure
- Shared package c1355_test_pkg holds:
  - C1355_OUT_W=32 and C1355_IN_W=41.
  - The default POLY and SEED.
  - The FSM state enum (IDLE, RUN, DONE).
- One sub-module, misr_core:
  - Parameterized DATA_W, POLY.
  - Inputs: load, load_val, en, data_in.
  - Output: sig.
  - Contains the shift/XOR register only.
- The FSM, counter and compare live in the top level.

## Test plan
- Default parameters, SEED=0. Start, then resp=32'h0000_0001 followed by resp=0 with VEC_LEN=2 and golden=32'h0000_0002 → done=1 and pass=1 in the cycle after the 2nd capture; vec_count=2.
- SEED=32'h8000_0000, VEC_LEN=1, resp=0, golden=32'h04C1_1DB7 → signature=32'h04C1_1DB7, pass=1. Repeat with golden=0 → pass=0.
- VEC_LEN=64 with resp_valid toggling every other cycle → done asserts only after 64 captures; vec_count increments only on valid cycles; signature matches the reference model.
- Abort asserted together with resp_valid after 10 captures → IDLE next cycle; vec_count stays 10; done=0, pass=0. A following start → signature=SEED, vec_count=0.
- rst_n=0 for one cycle mid-RUN → next cycle all outputs are at their reset values; resp_valid pulses are then ignored until start.
- start pulsed in RUN and again in DONE → ignored in RUN; the DONE pulse restarts with pass=0 and signature=SEED.
